// File: rtl/msx_kbd_pkg.sv
`default_nettype none
// msx_kbd_pkg: matrix geometry, key-map entry type and set-2 scancodes shared by the MSX keyboard (rev 1.0)
package msx_kbd_pkg;

  localparam int MSX_ROWS = 11;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } msx_key_t;

  // {E0-extended, set-2 code} for arrows and modifiers
  localparam logic [8:0] SC_UP     = 9'h175;
  localparam logic [8:0] SC_DOWN   = 9'h172;
  localparam logic [8:0] SC_LEFT   = 9'h16B;
  localparam logic [8:0] SC_RIGHT  = 9'h174;
  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;
  localparam logic [8:0] SC_LCTRL  = 9'h014;
  localparam logic [8:0] SC_RCTRL  = 9'h114;
  localparam logic [8:0] SC_LALT   = 9'h011;
  localparam logic [8:0] SC_RALT   = 9'h111;

  function automatic msx_key_t mk_key(input logic [3:0] r, input logic [2:0] c);
    mk_key = '{hit: 1'b1, row: r, col: c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/msx_key_map.sv
`default_nettype none
// msx_key_map: combinational {ext,code} -> MSX matrix position table (rev 1.0)
module msx_key_map
  import msx_kbd_pkg::*;
(
  input  logic [8:0] scan,
  output msx_key_t   key
);

  always_comb begin
    key = '0;
    case (scan)
      9'h045: key = mk_key(4'd0, 3'd0);
      9'h016: key = mk_key(4'd0, 3'd1);
      9'h01E: key = mk_key(4'd0, 3'd2);
      9'h026: key = mk_key(4'd0, 3'd3);
      9'h025: key = mk_key(4'd0, 3'd4);
      9'h02E: key = mk_key(4'd0, 3'd5);
      9'h036: key = mk_key(4'd0, 3'd6);
      9'h03D: key = mk_key(4'd0, 3'd7);
      9'h03E: key = mk_key(4'd1, 3'd0);
      9'h046: key = mk_key(4'd1, 3'd1);
      9'h04E: key = mk_key(4'd1, 3'd2);
      9'h055: key = mk_key(4'd1, 3'd3);
      9'h05D: key = mk_key(4'd1, 3'd4);
      9'h054: key = mk_key(4'd1, 3'd5);
      9'h05B: key = mk_key(4'd1, 3'd6);
      9'h04C: key = mk_key(4'd1, 3'd7);
      9'h052: key = mk_key(4'd2, 3'd0);
      9'h00E: key = mk_key(4'd2, 3'd1);
      9'h041: key = mk_key(4'd2, 3'd2);
      9'h049: key = mk_key(4'd2, 3'd3);
      9'h04A: key = mk_key(4'd2, 3'd4);
      9'h01C: key = mk_key(4'd2, 3'd6);
      9'h032: key = mk_key(4'd2, 3'd7);
      9'h021: key = mk_key(4'd3, 3'd0);
      9'h023: key = mk_key(4'd3, 3'd1);
      9'h024: key = mk_key(4'd3, 3'd2);
      9'h02B: key = mk_key(4'd3, 3'd3);
      9'h034: key = mk_key(4'd3, 3'd4);
      9'h033: key = mk_key(4'd3, 3'd5);
      9'h043: key = mk_key(4'd3, 3'd6);
      9'h03B: key = mk_key(4'd3, 3'd7);
      9'h042: key = mk_key(4'd4, 3'd0);
      9'h04B: key = mk_key(4'd4, 3'd1);
      9'h03A: key = mk_key(4'd4, 3'd2);
      9'h031: key = mk_key(4'd4, 3'd3);
      9'h044: key = mk_key(4'd4, 3'd4);
      9'h04D: key = mk_key(4'd4, 3'd5);
      9'h015: key = mk_key(4'd4, 3'd6);
      9'h02D: key = mk_key(4'd4, 3'd7);
      9'h01B: key = mk_key(4'd5, 3'd0);
      9'h02C: key = mk_key(4'd5, 3'd1);
      9'h03C: key = mk_key(4'd5, 3'd2);
      9'h02A: key = mk_key(4'd5, 3'd3);
      9'h01D: key = mk_key(4'd5, 3'd4);
      9'h022: key = mk_key(4'd5, 3'd5);
      9'h035: key = mk_key(4'd5, 3'd6);
      9'h01A: key = mk_key(4'd5, 3'd7);
      SC_LSHIFT, SC_RSHIFT: key = mk_key(4'd6, 3'd0);
      SC_LCTRL, SC_RCTRL:   key = mk_key(4'd6, 3'd1);
      SC_LALT:  key = mk_key(4'd6, 3'd2);
      9'h058:   key = mk_key(4'd6, 3'd3);
      SC_RALT:  key = mk_key(4'd6, 3'd4);
      9'h005:   key = mk_key(4'd6, 3'd5);
      9'h006:   key = mk_key(4'd6, 3'd6);
      9'h004:   key = mk_key(4'd6, 3'd7);
      9'h00C:   key = mk_key(4'd7, 3'd0);
      9'h003:   key = mk_key(4'd7, 3'd1);
      9'h076:   key = mk_key(4'd7, 3'd2);
      9'h00D:   key = mk_key(4'd7, 3'd3);
      9'h00A:   key = mk_key(4'd7, 3'd4);
      9'h066:   key = mk_key(4'd7, 3'd5);
      9'h083:   key = mk_key(4'd7, 3'd6);
      9'h05A, 9'h15A: key = mk_key(4'd7, 3'd7);
      9'h029:   key = mk_key(4'd8, 3'd0);
      9'h16C:   key = mk_key(4'd8, 3'd1);
      9'h170:   key = mk_key(4'd8, 3'd2);
      9'h171:   key = mk_key(4'd8, 3'd3);
      SC_LEFT:  key = mk_key(4'd8, 3'd4);
      SC_UP:    key = mk_key(4'd8, 3'd5);
      SC_DOWN:  key = mk_key(4'd8, 3'd6);
      SC_RIGHT: key = mk_key(4'd8, 3'd7);
      // numeric keypad: non-extended codes that share values with the E0 navigation keys
      9'h07C:   key = mk_key(4'd9, 3'd0);
      9'h079:   key = mk_key(4'd9, 3'd1);
      9'h14A:   key = mk_key(4'd9, 3'd2);
      9'h070:   key = mk_key(4'd9, 3'd3);
      9'h069:   key = mk_key(4'd9, 3'd4);
      9'h072:   key = mk_key(4'd9, 3'd5);
      9'h07A:   key = mk_key(4'd9, 3'd6);
      9'h06B:   key = mk_key(4'd9, 3'd7);
      9'h073:   key = mk_key(4'd10, 3'd0);
      9'h074:   key = mk_key(4'd10, 3'd1);
      9'h06C:   key = mk_key(4'd10, 3'd2);
      9'h075:   key = mk_key(4'd10, 3'd3);
      9'h07D:   key = mk_key(4'd10, 3'd4);
      9'h07B:   key = mk_key(4'd10, 3'd5);
      9'h071:   key = mk_key(4'd10, 3'd7);
      default:  key = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/msx_keyboard.sv
`default_nettype none
// msx_keyboard: ps2_key toggle-event consumer holding the MSX key matrix for PPI port B (rev 1.0)
module msx_keyboard
  import msx_kbd_pkg::*;
#(
  parameter int ROWS = MSX_ROWS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        key_clear,
  input  logic [3:0]  row_sel,
  output logic [7:0]  row_data,
  output logic        key_strobe
);

  logic       primed;
  logic       tog_q;
  logic       ev_v;
  logic [9:0] ev_q;
  logic       map_v;
  logic       map_press;
  msx_key_t   map_q;
  msx_key_t   map_w;
  logic       upd;
  logic [7:0] matrix [ROWS];

  msx_key_map u_map (
    .scan (ev_q[8:0]),
    .key  (map_w)
  );

  // Priming cycle only samples the toggle so a level left over across reset is not an event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed    <= 1'b0;
      tog_q     <= 1'b0;
      ev_v      <= 1'b0;
      ev_q      <= '0;
      map_v     <= 1'b0;
      map_press <= 1'b0;
      map_q     <= '0;
    end else begin
      primed    <= 1'b1;
      tog_q     <= ps2_key[10];
      ev_v      <= primed && (ps2_key[10] != tog_q);
      if (primed && (ps2_key[10] != tog_q))
        ev_q    <= ps2_key[9:0];
      map_v     <= ev_v;
      map_press <= ev_q[9];
      map_q     <= map_w;
    end
  end

  assign upd        = map_v & map_q.hit;
  assign key_strobe = upd & ~key_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++)
        matrix[r] <= 8'hFF;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (key_clear)
          matrix[r] <= 8'hFF;
        else if (upd && (map_q.row == 4'(r)))
          matrix[r][map_q.col] <= ~map_press;
      end
    end
  end

  always_comb begin
    row_data = 8'hFF;
    for (int i = 0; i < ROWS; i++)
      if (row_sel == 4'(i))
        row_data = matrix[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_msx_keyboard.sv
`default_nettype none
`timescale 1ns/100ps
// tb_msx_keyboard: scoreboard bench for the MSX keyboard matrix (rev 1.0)
module tb_msx_keyboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        key_clear;
  logic [3:0]  row_sel;
  logic [7:0]  row_data;
  logic        key_strobe;
  logic        tog;

  typedef struct {
    int         due;
    logic [3:0] row;
    logic [2:0] col;
    logic       press;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [16];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_mis = 0;

  msx_keyboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .key_clear  (key_clear),
    .row_sel    (row_sel),
    .row_data   (row_data),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  // Reference subset of the key map: {hit,row[3:0],col[2:0]}
  function automatic logic [7:0] tb_map(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h01C:  return {1'b1, 4'd2,  3'd6};
      9'h029:  return {1'b1, 4'd8,  3'd0};
      9'h012:  return {1'b1, 4'd6,  3'd0};
      9'h076:  return {1'b1, 4'd7,  3'd2};
      9'h175:  return {1'b1, 4'd8,  3'd5};
      9'h075:  return {1'b1, 4'd10, 3'd3};
      9'h016:  return {1'b1, 4'd0,  3'd1};
      9'h005:  return {1'b1, 4'd6,  3'd5};
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      for (int r = 0; r < 16; r++) mdl[r] = 8'hFF;
      sb.delete();
    end else begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("strobe_missing", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      if (key_strobe) begin
        if (sb.size() == 0) begin
          chk("strobe_spurious", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.due);
          mdl[e.row][e.col] = ~e.press;
        end
      end
      if (key_clear)
        for (int r = 0; r < 16; r++) mdl[r] = 8'hFF;
    end
  end

  task automatic send(input logic press, input logic ext, input logic [7:0] code, input bit keep);
    logic [7:0] m;
    @(posedge clk); #1;
    tog = ~tog;
    ps2_key = {tog, press, ext, code};
    m = tb_map(ext, code);
    if (m[7] && keep)
      sb.push_back('{cyc + 2, m[6:3], m[2:0], press});
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 16; r++) begin
      row_sel = 4'(r);
      #0.2;
      chk($sformatf("%s_row%0d", tag, r), {24'd0, row_data}, {24'd0, mdl[r]});
    end
  endtask

  task automatic check_row(input string tag, input logic [3:0] r, input logic [7:0] v);
    row_sel = r;
    #0.2;
    chk(tag, {24'd0, row_data}, {24'd0, v});
  endtask

  initial begin
    reset_n   = 1'b0;
    tog       = 1'b1;
    ps2_key   = {1'b1, 10'h000};
    key_clear = 1'b0;
    row_sel   = 4'd0;
    settle(3);
    check_rows("reset");
    chk("reset_strobe", {31'd0, key_strobe}, 32'd0);

    // toggle left high across reset must not be an event
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("prime_strobe", {31'd0, key_strobe}, 32'd0);
    end
    check_rows("prime");

    // press A: unchanged at N+2, visible at N+3
    send(1'b1, 1'b0, 8'h1C, 1'b1);
    repeat (3) @(negedge clk);
    check_row("lat_n2", 4'd2, 8'hFF);
    @(negedge clk);
    check_row("press_a", 4'd2, 8'hBF);

    send(1'b0, 1'b0, 8'h1C, 1'b1);
    settle(3);
    check_row("release_a", 4'd2, 8'hFF);

    // typematic repeat and release of a key never pressed
    send(1'b1, 1'b0, 8'h1C, 1'b1);
    send(1'b1, 1'b0, 8'h1C, 1'b1);
    send(1'b0, 1'b0, 8'h29, 1'b1);
    settle(3);
    check_row("typematic", 4'd2, 8'hBF);
    check_row("rel_unpressed", 4'd8, 8'hFF);
    send(1'b0, 1'b0, 8'h1C, 1'b1);
    settle(3);
    check_rows("after_typ");

    // E0 75 (Up) and plain 75 (keypad 8) back to back
    send(1'b1, 1'b1, 8'h75, 1'b1);
    send(1'b1, 1'b0, 8'h75, 1'b1);
    settle(3);
    check_row("up_row8", 4'd8, 8'hDF);
    check_row("kp8_row10", 4'd10, 8'hF7);
    send(1'b0, 1'b1, 8'h75, 1'b1);
    send(1'b0, 1'b0, 8'h75, 1'b1);
    settle(3);

    // key_clear coincident with Esc reaching the update stage
    send(1'b1, 1'b0, 8'h1C, 1'b1);
    send(1'b1, 1'b0, 8'h29, 1'b1);
    send(1'b1, 1'b0, 8'h12, 1'b1);
    settle(3);
    check_rows("multi");
    send(1'b1, 1'b0, 8'h76, 1'b0);
    @(posedge clk);
    @(posedge clk); #1 key_clear = 1'b1;
    @(negedge clk);
    chk("clr_strobe", {31'd0, key_strobe}, 32'd0);
    @(posedge clk); #1 key_clear = 1'b0;
    @(negedge clk);
    check_rows("clear");

    // unmapped codes leave the matrix alone
    send(1'b1, 1'b0, 8'h16, 1'b1);
    send(1'b1, 1'b0, 8'h05, 1'b1);
    send(1'b1, 1'b1, 8'h12, 1'b1);
    send(1'b1, 1'b0, 8'h00, 1'b1);
    settle(4);
    check_row("one_row0", 4'd0, 8'hFD);
    check_row("f1_row6", 4'd6, 8'hDF);
    check_rows("unmapped");

    // async reset with an event in flight
    send(1'b1, 1'b0, 8'h1C, 1'b1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    for (int r = 0; r < 16; r++) begin
      row_sel = 4'(r);
      #0.1;
      chk($sformatf("async_rst_row%0d", r), {24'd0, row_data}, 32'h0000_00FF);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("flush_strobe", {31'd0, key_strobe}, 32'd0);
    end
    check_rows("post_rst");

    send(1'b1, 1'b0, 8'h29, 1'b1);
    settle(3);
    check_row("reprime_space", 4'd8, 8'hFE);
    settle(2);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
